axi_stream_extract_header: RTL

- Receive-side counterpart of the header-insert block.
- Strips the first L bytes of every AXI-Stream packet and presents them on a separate header port.
- Re-aligns the remaining payload bytes MSB-first onto a full-width AXI-Stream output.
- Sits after the link/parser input, ahead of payload consumers.

---
 rtl/axi_stream_hdr_pkg.sv | 43 ++++
 rtl/axi_stream_extract_header_if.sv | 38 +++
 rtl/axis_byte_realign.sv | 19 +
 rtl/axi_stream_extract_header.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and byte-count/keep helpers for the AXI-Stream header insert/extract blocks.
package axi_stream_hdr_pkg;

  localparam int unsigned MAX_BYTES = 64;
  localparam int unsigned CNT_WD    = 8;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Popcount of a contiguous keep vector, zero-extended to MAX_BYTES.
  function automatic logic [CNT_WD-1:0] keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c = c + CNT_WD'(keep[i]);
    end
    return c;
  endfunction

  function automatic logic [MAX_BYTES-1:0] cnt_to_keep_lsb(input logic [CNT_WD-1:0] cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < int'(cnt));
    end
    return m;
  endfunction

  // Top cnt lanes of an nbytes-wide keep; caller truncates to nbytes.
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep_msb(input logic [CNT_WD-1:0] cnt,
                                                           input logic [CNT_WD-1:0] nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < int'(nbytes)) && (i >= (int'(nbytes) - int'(cnt)));
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// Input stream, payload stream and header port of the header extractor.
interface axi_stream_extract_header_if #(
  parameter int unsigned DATA_WD = 32
);
  localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_header;
  logic [DATA_WD-1:0]      data_header;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    ready_header;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, byte_remove_cnt, ready_out, ready_header,
    output ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, data_header, keep_header
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, byte_remove_cnt, ready_out, ready_header,
    input  ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, data_header, keep_header
  );

endinterface

// File: rtl/axis_byte_realign.sv
// Merges an MSB-aligned residual of res_cnt bytes with the top bytes of the next beat.
module axis_byte_realign #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned CW      = 4
) (
  input  logic [DATA_WD-1:0] res_i,
  input  logic [CW-1:0]      res_cnt_i,
  input  logic [DATA_WD-1:0] data_i,
  output logic [DATA_WD-1:0] merged_c_o,
  output logic [DATA_WD-1:0] next_res_c_o
);

  localparam logic [CW-1:0] DB_CNT = CW'(DATA_WD / 8);

  // res_i is zero below its valid bytes, so OR-ing the shifted beat is a clean merge.
  assign merged_c_o   = res_i | (data_i >> {res_cnt_i, 3'b000});
  assign next_res_c_o = (res_cnt_i == '0) ? '0 : (data_i << {DB_CNT - res_cnt_i, 3'b000});

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the first L bytes of each packet onto a header port and re-aligns the payload.
module axi_stream_extract_header
  import axi_stream_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_stream_extract_header_if.slave  bus
);

  localparam int unsigned DB          = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD = $clog2(DB);
  localparam int unsigned CW          = BYTE_CNT_WD + 2;
  localparam logic [CW-1:0] DB_CNT    = CW'(DB);

  function automatic logic [DB-1:0] msb_keep(input logic [CW-1:0] c);
    return DB'(cnt_to_keep_msb(CNT_WD'(c), CNT_WD'(DB)));
  endfunction

  state_e               state_q, state_d;
  logic [DATA_WD-1:0]   res_q, res_d;
  logic [CW-1:0]        res_cnt_q, res_cnt_d;

  logic                 pay_valid_q, pay_valid_d;
  logic [DATA_WD-1:0]   pay_data_q, pay_data_d;
  logic [DB-1:0]        pay_keep_q, pay_keep_d;
  logic                 pay_last_q, pay_last_d;
  logic                 hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]   hdr_data_q, hdr_data_d;
  logic [DB-1:0]        hdr_keep_q, hdr_keep_d;

  logic                 ready_in_c;
  logic                 pay_free, hdr_free;
  logic [DATA_WD-1:0]   data_m;
  logic [CW-1:0]        n_in, hdr_len, hdr_take, first_r, total;
  logic [DATA_WD-1:0]   merged, next_res;

  assign pay_free = !pay_valid_q || bus.ready_out;
  assign hdr_free = !hdr_valid_q || bus.ready_header;

  // Zero invalid input lanes so pad bytes downstream are always 0.
  always_comb begin
    data_m = '0;
    for (int b = 0; b < DB; b++) begin
      data_m[8*b +: 8] = bus.data_in[8*b +: 8] & {8{bus.keep_in[b]}};
    end
  end

  assign n_in     = CW'(keep_to_cnt(MAX_BYTES'(bus.keep_in)));
  assign hdr_len  = CW'(bus.byte_remove_cnt) + CW'(1);
  assign hdr_take = (n_in < hdr_len) ? n_in : hdr_len;
  assign first_r  = (n_in > hdr_len) ? (n_in - hdr_len) : '0;
  assign total    = res_cnt_q + n_in;

  axis_byte_realign #(
    .DATA_WD (DATA_WD),
    .CW      (CW)
  ) u_realign (
    .res_i        (res_q),
    .res_cnt_i    (res_cnt_q),
    .data_i       (data_m),
    .merged_c_o   (merged),
    .next_res_c_o (next_res)
  );

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    pay_valid_d = pay_valid_q && !bus.ready_out;
    pay_data_d  = pay_data_q;
    pay_keep_d  = pay_keep_q;
    pay_last_d  = pay_last_q;
    hdr_valid_d = hdr_valid_q && !bus.ready_header;
    hdr_data_d  = hdr_data_q;
    hdr_keep_d  = hdr_keep_q;
    ready_in_c  = 1'b0;

    unique case (state_q)
      FIRST: begin
        ready_in_c = pay_free && hdr_free;
        if (bus.valid_in && ready_in_c) begin
          hdr_valid_d = 1'b1;
          hdr_data_d  = data_m >> {DB_CNT - hdr_take, 3'b000};
          hdr_keep_d  = DB'(cnt_to_keep_lsb(CNT_WD'(hdr_take)));
          res_d       = data_m << {hdr_len, 3'b000};
          res_cnt_d   = first_r;
          if (bus.last_in) begin
            // Whole packet in one beat: leftover bytes form the only payload beat.
            if (first_r != '0) begin
              pay_valid_d = 1'b1;
              pay_data_d  = data_m << {hdr_len, 3'b000};
              pay_keep_d  = msb_keep(first_r);
              pay_last_d  = 1'b1;
            end
            res_d     = '0;
            res_cnt_d = '0;
          end else begin
            state_d = BODY;
          end
        end
      end

      BODY: begin
        ready_in_c = pay_free;
        if (bus.valid_in && ready_in_c) begin
          pay_valid_d = 1'b1;
          pay_data_d  = merged;
          pay_keep_d  = '1;
          pay_last_d  = 1'b0;
          res_d       = next_res;
          if (bus.last_in) begin
            if (total <= DB_CNT) begin
              pay_keep_d = msb_keep(total);
              pay_last_d = 1'b1;
              res_d      = '0;
              res_cnt_d  = '0;
              state_d    = FIRST;
            end else begin
              res_cnt_d = total - DB_CNT;
              state_d   = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        if (pay_free) begin
          pay_valid_d = 1'b1;
          pay_data_d  = res_q;
          pay_keep_d  = msb_keep(res_cnt_q);
          pay_last_d  = 1'b1;
          res_d       = '0;
          res_cnt_d   = '0;
          state_d     = FIRST;
        end
      end

      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIRST;
      res_q       <= '0;
      res_cnt_q   <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_keep_q  <= '0;
      pay_last_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_keep_q  <= pay_keep_d;
      pay_last_q  <= pay_last_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_data_q  <= hdr_data_d;
      hdr_keep_q  <= hdr_keep_d;
    end
  end

  assign bus.ready_in     = ready_in_c;
  assign bus.valid_out    = pay_valid_q;
  assign bus.data_out     = pay_data_q;
  assign bus.keep_out     = pay_keep_q;
  assign bus.last_out     = pay_last_q;
  assign bus.valid_header = hdr_valid_q;
  assign bus.data_header  = hdr_data_q;
  assign bus.keep_header  = hdr_keep_q;

endmodule
